// File: rtl/spi_pkg.sv
// Shared opcode and FSM state definitions for the SPI-RAM command path.
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdReq  = 2'd1,
        StRdCap  = 2'd2,
        StRdHold = 2'd3
    } state_e;

endpackage

// File: rtl/spi_mem_ctrl.sv
// Command sequencer between the SPI slave and a single-port synchronous RAM.
// Optional address auto-increment is enabled by defining SPI_MEM_AUTO_INC_EN.
module spi_mem_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ack,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_addr_ok_q, wr_addr_ok_d;
    logic                  rd_addr_ok_q, rd_addr_ok_d;
    logic                  rx_valid_q;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  err_q, err_d;

    logic                  cmd_stb;
    logic [1:0]            opcode;
    logic [ADDR_WIDTH-1:0] payload_addr;

    assign cmd_stb      = rx_valid & ~rx_valid_q;
    assign opcode       = rx_data[9:8];
    assign payload_addr = rx_data[ADDR_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_ok_d = wr_addr_ok_q;
        rd_addr_ok_d = rd_addr_ok_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = 8'h00;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_stb) begin
                    unique case (opcode)
                        OP_WR_ADDR: begin
                            wr_addr_d    = payload_addr;
                            wr_addr_ok_d = 1'b1;
                        end
                        OP_WR_DATA: begin
                            if (wr_addr_ok_q) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = wr_addr_q;
                                mem_wdata_d = rx_data[7:0];
`ifdef SPI_MEM_AUTO_INC_EN
                                wr_addr_d   = wr_addr_q + 1'b1;
`endif
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RD_ADDR: begin
                            rd_addr_d    = payload_addr;
                            rd_addr_ok_d = 1'b1;
                        end
                        OP_RD_DATA: begin
                            if (rd_addr_ok_q) begin
                                state_d    = StRdReq;
                                mem_re_d   = 1'b1;
                                mem_addr_d = rd_addr_q;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            StRdReq: begin
                state_d = StRdCap;
`ifdef SPI_MEM_AUTO_INC_EN
                rd_addr_d = rd_addr_q + 1'b1;
`endif
            end
            StRdCap: begin
                tx_data_d  = mem_rdata;
                tx_valid_d = 1'b1;
                state_d    = StRdHold;
            end
            StRdHold: begin
                if (tx_ack) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
        endcase

        // Commands arriving mid-read are dropped; the ack above is still honoured.
        if (cmd_stb && state_q != StIdle) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_ok_q <= wr_addr_ok_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            rx_valid_q   <= rx_valid;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            assert (RD_LATENCY == 1 && ADDR_WIDTH <= 8)
                else $error("spi_mem_ctrl: unsupported RD_LATENCY or ADDR_WIDTH");
            assert (!(mem_we_q && mem_re_q))
                else $error("spi_mem_ctrl: mem_we and mem_re overlap");
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl: expected RAM cycles, errors and tx words are queued
// with their cycle number and checked by an independent monitor on the falling edge.
module tb_spi_mem_ctrl;

    localparam int KWe  = 0;
    localparam int KRe  = 1;
    localparam int KErr = 2;
    localparam int KTx  = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack = 1'b0;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       err;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       tx_prev = 1'b0;
    logic [7:0] ram [256];

    spi_mem_ctrl #(
        .ADDR_WIDTH (8),
        .RD_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ack    (tx_ack),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic push(input int k, input int c, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic match(input int k, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bit   ok;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%02h data=%02h at cyc %0d, none expected",
                     k, a, d, cyc);
        end else begin
            e  = q.pop_front();
            ok = (e.kind == k) && (e.cyc == cyc);
            if (k == KWe) ok = ok && (e.addr == a) && (e.data == d);
            if (k == KRe) ok = ok && (e.addr == a);
            if (k == KTx) ok = ok && (e.data == d);
            if (!ok) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d addr=%02h data=%02h, want kind=%0d cyc=%0d addr=%02h data=%02h",
                         k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
            if (!mem_we && !mem_re) chk("idle_mem_addr", {24'd0, mem_addr}, 32'd0);
            if (mem_we) match(KWe, mem_addr, mem_wdata);
            if (mem_re) match(KRe, mem_addr, 8'h00);
            if (err) match(KErr, 8'h00, 8'h00);
            if (tx_valid && !tx_prev) match(KTx, 8'h00, tx_data);
        end
        tx_prev = tx_valid;
    end

    task automatic start(input logic [9:0] w, output int e0);
        @(posedge clk);
        #1;
        rx_data  = w;
        rx_valid = 1'b1;
        e0       = cyc + 1;
    endtask

    task automatic drop(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx();
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        chk("tx_valid_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic ack();
        @(posedge clk);
        #1 tx_ack = 1'b1;
        @(posedge clk);
        #1 tx_ack = 1'b0;
        @(negedge clk);
        chk("tx_valid_after_ack", {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h10] = 8'h3C;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        #1 rst = 1'b0;

        // Missing addresses after reset
        start(10'h1FF, e0); push(KErr, e0, 8'h00, 8'h00); drop(1);
        start(10'h3FF, e0); push(KErr, e0, 8'h00, 8'h00); drop(1);

        // Write path
        start(10'h005, e0); drop(1);
        start(10'h1A5, e0); push(KWe, e0, 8'h05, 8'hA5); drop(1);

        // Held rx_valid gives a single write
        start(10'h030, e0); drop(1);
        start(10'h1A5, e0); push(KWe, e0, 8'h30, 8'hA5); drop(4);

        // Read path with 5-cycle hold before ack
        start(10'h210, e0); drop(1);
        start(10'h300, e0); push(KRe, e0, 8'h10, 8'h00); push(KTx, e0 + 2, 8'h00, 8'h3C); drop(1);
        wait_tx();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_tx_valid", {31'd0, tx_valid}, 32'd1);
            chk("hold_tx_data", {24'd0, tx_data}, 32'h3C);
        end
        ack();

        // Busy drop, then simultaneous ack and command
        start(10'h040, e0); drop(1);
        start(10'h210, e0); drop(1);
        start(10'h300, e0); push(KRe, e0, 8'h10, 8'h00); push(KTx, e0 + 2, 8'h00, 8'h3C); drop(1);
        wait_tx();
        start(10'h077, e0); push(KErr, e0, 8'h00, 8'h00); drop(1);
        start(10'h077, e0); push(KErr, e0, 8'h00, 8'h00);
        tx_ack = 1'b1;
        drop(1);
        tx_ack = 1'b0;
        @(negedge clk);
        chk("simul_ack_tx_valid", {31'd0, tx_valid}, 32'd0);
        start(10'h1EE, e0); push(KWe, e0, 8'h40, 8'hEE); drop(1);

        // Reset while in RD_CAP
        start(10'h210, e0); drop(1);
        start(10'h300, e0); push(KRe, e0, 8'h10, 8'h00); drop(1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_read_tx_valid", {31'd0, tx_valid}, 32'd0);
        end
        start(10'h300, e0); push(KErr, e0, 8'h00, 8'h00); drop(1);
        start(10'h1AA, e0); push(KErr, e0, 8'h00, 8'h00); drop(1);

        // Address wrap / hold at 0xFF
        start(10'h0FF, e0); drop(1);
        start(10'h111, e0); push(KWe, e0, 8'hFF, 8'h11); drop(1);
`ifdef SPI_MEM_AUTO_INC_EN
        start(10'h122, e0); push(KWe, e0, 8'h00, 8'h22); drop(1);
`else
        start(10'h122, e0); push(KWe, e0, 8'hFF, 8'h22); drop(1);
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
